fft_ctrl: RTL and testbench

Sequencer for an in-place radix-2 decimation-in-time FFT built around the combinational butterfly unit (DINA/DINB/twiddle -> DOUTA/DOUTB). The butterfly works on 32-bit complex words: real part in [31:16], imaginary part in [15:0], each 16-bit sign-magnitude.
- Generates read/write addresses for a true dual-port sample RAM with synchronous read.
- Generates the twiddle ROM address.
- Controls stage progression and start/busy/done handshaking.
- Input samples are stored in bit-reversed order in the RAM before start. Results are left in natural order.

---
 rtl/fft_ctrl_if.sv | 48 ++++
 rtl/fft_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_fft_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_ctrl_if.sv
// -----------------------------------------------------------------------------
// fft_ctrl_if
// Handshake and RAM/ROM addressing bundle between the radix-2 FFT sequencer
// and the datapath it drives (dual-port sample RAM, twiddle ROM, butterfly).
//
//   start      : begin a transform (sampled by the sequencer only when idle)
//   busy       : transform in progress
//   done       : one-cycle pulse after the final write has been issued
//   rd_en      : sample RAM read enable (both ports) / twiddle ROM enable
//   rd_addr_a/b: butterfly top / bottom read addresses
//   tw_addr    : twiddle ROM address, aligned with rd_en
//   wr_en      : sample RAM write enable (both ports)
//   wr_addr_a/b: butterfly top / bottom write-back addresses
//   stage      : current stage index
//
// Modports: master = the sequencer, slave = the datapath / start requester.
// -----------------------------------------------------------------------------
interface fft_ctrl_if #(
    parameter int LOG2N = 4
);
    localparam int AW = LOG2N;
    localparam int TW = LOG2N - 1;
    localparam int SW = (LOG2N > 2) ? $clog2(LOG2N) : 1;

    logic          start;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [TW-1:0] tw_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr_a;
    logic [AW-1:0] wr_addr_b;
    logic [SW-1:0] stage;

    modport master (
        input  start,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
        output wr_en, wr_addr_a, wr_addr_b, stage
    );

    modport slave (
        output start,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
        input  wr_en, wr_addr_a, wr_addr_b, stage
    );
endinterface

// File: rtl/fft_ctrl.sv
// -----------------------------------------------------------------------------
// fft_ctrl
// Sequencer for an in-place radix-2 decimation-in-time FFT. Samples are
// expected in bit-reversed order in the RAM; results end in natural order.
// One butterfly is issued per cycle; each stage is followed by a single
// bubble cycle (DRAIN) so the stage's last write lands before the next
// stage's first read.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : fft_ctrl_if.master (start in; busy/done, RAM and ROM addressing,
//           write-back control and stage index out). All outputs registered.
// -----------------------------------------------------------------------------
module fft_ctrl #(
    parameter int LOG2N = 4
) (
    input  logic       clk,
    input  logic       reset,
    fft_ctrl_if.master bus
);
    localparam int N      = 1 << LOG2N;
    localparam int HALF_N = N / 2;
    localparam int AW     = LOG2N;
    localparam int TW     = LOG2N - 1;
    localparam int SW     = (LOG2N > 2) ? $clog2(LOG2N) : 1;
    localparam int JW     = LOG2N - 1;

    localparam logic [JW-1:0] J_LAST = JW'(HALF_N - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_nxt_state;
    logic [JW-1:0] r_j;
    logic [JW-1:0] w_nxt_j;
    logic [SW-1:0] r_stage;
    logic [SW-1:0] w_nxt_stage;

    logic          r_busy;
    logic          r_done;
    logic          r_rd_en;
    logic [AW-1:0] r_rd_addr_a;
    logic [AW-1:0] r_rd_addr_b;
    logic [TW-1:0] r_tw_addr;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr_a;
    logic [AW-1:0] r_wr_addr_b;

    logic [AW-1:0] w_rd_addr_a;
    logic [AW-1:0] w_rd_addr_b;
    logic [TW-1:0] w_tw_addr;

    // Top input of butterfly j in stage s: the group index (j >> s) selects a
    // block of 2*half samples, the low s bits select the position inside it.
    function automatic logic [AW-1:0] f_addr_a(input logic [JW-1:0] j,
                                               input logic [SW-1:0] s);
        logic [AW-1:0] jj;
        logic [AW-1:0] mask;
        jj   = {1'b0, j};
        mask = (AW'(1) << s) - AW'(1);
        return ((jj >> s) << (int'(s) + 1)) | (jj & mask);
    endfunction

    function automatic logic [AW-1:0] f_half(input logic [SW-1:0] s);
        return AW'(1) << s;
    endfunction

    // Twiddle exponent scaled so that stage s strides the N/2-entry table
    // in steps of N/(2*half).
    function automatic logic [TW-1:0] f_tw(input logic [JW-1:0] j,
                                           input logic [SW-1:0] s);
        logic [AW-1:0] jj;
        logic [AW-1:0] mask;
        logic [AW-1:0] sh;
        jj   = {1'b0, j};
        mask = (AW'(1) << s) - AW'(1);
        sh   = (jj & mask) << (LOG2N - 1 - int'(s));
        return sh[TW-1:0];
    endfunction

    // Addresses are computed from the next j/stage so they register
    // together with rd_en.
    assign w_rd_addr_a = f_addr_a(w_nxt_j, w_nxt_stage);
    assign w_rd_addr_b = w_rd_addr_a + f_half(w_nxt_stage);
    assign w_tw_addr   = f_tw(w_nxt_j, w_nxt_stage);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_j     <= '0;
            r_stage <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_j     <= w_nxt_j;
            r_stage <= w_nxt_stage;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_j     = r_j;
        w_nxt_stage = r_stage;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_nxt_state = S_RUN;
                    w_nxt_j     = '0;
                    w_nxt_stage = '0;
                end
            end
            S_RUN: begin
                if (r_j == J_LAST) begin
                    w_nxt_state = S_DRAIN;
                end else begin
                    w_nxt_j = r_j + 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_stage == S_LAST) begin
                    w_nxt_state = S_DONE;
                end else begin
                    w_nxt_state = S_RUN;
                    w_nxt_stage = r_stage + 1'b1;
                    w_nxt_j     = '0;
                end
            end
            S_DONE: begin
                w_nxt_state = S_IDLE;
                w_nxt_stage = '0;
                w_nxt_j     = '0;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    // Output registers; write side trails the read side by exactly one cycle
    // to match the synchronous RAM/ROM read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            r_tw_addr   <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr_a <= '0;
            r_wr_addr_b <= '0;
        end else begin
            r_busy  <= (w_nxt_state == S_RUN) || (w_nxt_state == S_DRAIN);
            r_done  <= (w_nxt_state == S_DONE);
            r_rd_en <= (w_nxt_state == S_RUN);
            if (w_nxt_state == S_RUN) begin
                r_rd_addr_a <= w_rd_addr_a;
                r_rd_addr_b <= w_rd_addr_b;
                r_tw_addr   <= w_tw_addr;
            end
            r_wr_en <= r_rd_en;
            if (r_rd_en) begin
                r_wr_addr_a <= r_rd_addr_a;
                r_wr_addr_b <= r_rd_addr_b;
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.rd_en     = r_rd_en;
    assign bus.rd_addr_a = r_rd_addr_a;
    assign bus.rd_addr_b = r_rd_addr_b;
    assign bus.tw_addr   = r_tw_addr;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr_a = r_wr_addr_a;
    assign bus.wr_addr_b = r_wr_addr_b;
    assign bus.stage     = r_stage;
endmodule

// File: tb/tb_fft_ctrl.sv
module tb_fft_ctrl;
    logic clk;
    logic reset;
    bit   chk_en;
    int   n_err;
    int   n_chk;

    fft_ctrl_if #(.LOG2N(4)) b4 ();
    fft_ctrl_if #(.LOG2N(3)) b3 ();

    fft_ctrl #(.LOG2N(4)) u4 (.clk(clk), .reset(reset), .bus(b4));
    fft_ctrl #(.LOG2N(3)) u3 (.clk(clk), .reset(reset), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Expected outputs during cycle t of a transform (t=0: idle, t=1: first
    // issued butterfly). Each stage is N/2 butterflies plus one bubble.
    function automatic void model_outs(input int lg, input int t,
                                       output int busy, output int done,
                                       output int rd, output int a,
                                       output int b, output int tw,
                                       output int stg);
        int half_n, per, total, pos, h, j;
        half_n = 1 << (lg - 1);
        per    = half_n + 1;
        total  = lg * per;
        busy = 0; done = 0; rd = 0; a = 0; b = 0; tw = 0; stg = 0;
        if (t >= 1 && t <= total) begin
            busy = 1;
            stg  = (t - 1) / per;
            pos  = (t - 1) % per;
            if (pos < half_n) begin
                rd = 1;
                j  = pos;
                h  = 1 << stg;
                a  = ((j >> stg) << (stg + 1)) | (j & (h - 1));
                b  = a + h;
                tw = (j & (h - 1)) << (lg - 1 - stg);
            end
        end
        if (t == total + 1) done = 1;
    endfunction

    task automatic step_model(input int lg, input logic st, inout int t,
                              inout int wr, inout int wa, inout int wb);
        int bz, dn, rd, a, b, tw, stg, total;
        total = lg * ((1 << (lg - 1)) + 1);
        if (reset) begin
            t = 0; wr = 0; wa = 0; wb = 0;
        end else begin
            model_outs(lg, t, bz, dn, rd, a, b, tw, stg);
            wr = rd;
            if (rd != 0) begin
                wa = a;
                wb = b;
            end
            if (t == 0) begin
                if (st) t = 1;
            end else if (t >= total + 1) begin
                t = 0;
            end else begin
                t = t + 1;
            end
        end
    endtask

    int m4_t, m4_wr, m4_wa, m4_wb;
    int m3_t, m3_wr, m3_wa, m3_wb;

    always @(posedge clk) begin
        step_model(4, b4.start, m4_t, m4_wr, m4_wa, m4_wb);
        step_model(3, b3.start, m3_t, m3_wr, m3_wa, m3_wb);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_bus(input string tag, input int lg, input int t,
                           input int wr, input int wa, input int wb,
                           input logic a_busy, input logic a_done,
                           input logic a_rd, input logic [31:0] a_ra,
                           input logic [31:0] a_rb, input logic [31:0] a_tw,
                           input logic a_wr, input logic [31:0] a_wa,
                           input logic [31:0] a_wb, input logic [31:0] a_stg);
        int bz, dn, rd, a, b, tw, stg;
        model_outs(lg, t, bz, dn, rd, a, b, tw, stg);
        check({tag, ".busy"}, 32'(a_busy), bz);
        check({tag, ".done"}, 32'(a_done), dn);
        check({tag, ".rd_en"}, 32'(a_rd), rd);
        check({tag, ".wr_en"}, 32'(a_wr), wr);
        check({tag, ".wr_addr_a"}, a_wa, wa);
        check({tag, ".wr_addr_b"}, a_wb, wb);
        if (rd != 0) begin
            check({tag, ".rd_addr_a"}, a_ra, a);
            check({tag, ".rd_addr_b"}, a_rb, b);
            check({tag, ".tw_addr"}, a_tw, tw);
        end
        if (bz != 0) check({tag, ".stage"}, a_stg, stg);
    endtask

    task automatic compare_all();
        cmp_bus("n16", 4, m4_t, m4_wr, m4_wa, m4_wb, b4.busy, b4.done, b4.rd_en,
                32'(b4.rd_addr_a), 32'(b4.rd_addr_b), 32'(b4.tw_addr), b4.wr_en,
                32'(b4.wr_addr_a), 32'(b4.wr_addr_b), 32'(b4.stage));
        cmp_bus("n8", 3, m3_t, m3_wr, m3_wa, m3_wb, b3.busy, b3.done, b3.rd_en,
                32'(b3.rd_addr_a), 32'(b3.rd_addr_b), 32'(b3.tw_addr), b3.wr_en,
                32'(b3.wr_addr_a), 32'(b3.wr_addr_b), 32'(b3.stage));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (chk_en) compare_all();
    endtask

    task automatic lit_idle4(input string tag);
        check({tag, ".busy"}, 32'(b4.busy), 0);
        check({tag, ".done"}, 32'(b4.done), 0);
        check({tag, ".rd_en"}, 32'(b4.rd_en), 0);
        check({tag, ".wr_en"}, 32'(b4.wr_en), 0);
        check({tag, ".stage"}, 32'(b4.stage), 0);
    endtask

    task automatic lit_addr4(input string tag, input int a, input int b, input int tw);
        check({tag, ".rd_en"}, 32'(b4.rd_en), 1);
        check({tag, ".rd_addr_a"}, 32'(b4.rd_addr_a), a);
        check({tag, ".rd_addr_b"}, 32'(b4.rd_addr_b), b);
        check({tag, ".tw_addr"}, 32'(b4.tw_addr), tw);
    endtask

    int busy_n, rd_n, wr_n, done_n, done_cyc, done2_cyc;

    initial begin
        n_err = 0;
        n_chk = 0;
        chk_en = 1'b0;
        reset = 1'b1;
        b4.start = 1'b1;
        b3.start = 1'b1;

        // Reset held three cycles with start high
        for (int k = 0; k < 3; k++) begin
            tick();
            lit_idle4($sformatf("reset%0d", k));
            check($sformatf("reset%0d.rd_addr_a", k), 32'(b4.rd_addr_a), 0);
            check($sformatf("reset%0d.wr_addr_b", k), 32'(b4.wr_addr_b), 0);
            check($sformatf("reset%0d.tw_addr", k), 32'(b4.tw_addr), 0);
            check($sformatf("reset%0d.n8_rd_en", k), 32'(b3.rd_en), 0);
        end
        reset = 1'b0;
        b4.start = 1'b0;
        b3.start = 1'b0;
        chk_en = 1'b1;
        tick();
        tick();

        // Full LOG2N=4 run with stray start pulses at cycles 5 and 20
        busy_n = 0; rd_n = 0; wr_n = 0; done_n = 0; done_cyc = -1;
        b4.start = 1'b1;
        tick();
        for (int k = 1; k <= 40; k++) begin
            if (b4.busy) busy_n++;
            if (b4.rd_en) rd_n++;
            if (b4.wr_en) wr_n++;
            if (b4.done) begin done_n++; done_cyc = k; end
            if (k == 9 || k == 18 || k == 27 || k == 36)
                check($sformatf("gap%0d.rd_en", k), 32'(b4.rd_en), 0);
            if (k == 1)  lit_addr4("s0j0", 0, 1, 0);
            if (k == 11) lit_addr4("s1j1", 1, 3, 4);
            if (k == 24) lit_addr4("s2j5", 9, 13, 2);
            if (k == 35) lit_addr4("s3j7", 7, 15, 7);
            if (k == 2) begin
                check("first_wr.wr_en", 32'(b4.wr_en), 1);
                check("first_wr.wr_addr_b", 32'(b4.wr_addr_b), 1);
            end
            b4.start = (k == 5 || k == 20);
            tick();
        end
        check("run.busy_cycles", busy_n, 36);
        check("run.rd_cycles", rd_n, 32);
        check("run.wr_cycles", wr_n, 32);
        check("run.done_pulses", done_n, 1);
        check("run.done_cycle", done_cyc, 37);

        // Reset in stage 2, then a clean restart
        b4.start = 1'b1;
        tick();
        b4.start = 1'b0;
        for (int k = 1; k < 22; k++) tick();
        check("pre_abort.stage", 32'(b4.stage), 2);
        reset = 1'b1;
        tick();
        lit_idle4("abort");
        reset = 1'b0;
        done_n = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (b4.done) done_n++;
        end
        check("abort.no_done", done_n, 0);
        busy_n = 0; done_cyc = -1;
        b4.start = 1'b1;
        tick();
        b4.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (b4.busy) busy_n++;
            if (b4.done) done_cyc = k;
            if (k == 1) lit_addr4("restart", 0, 1, 0);
            tick();
        end
        check("restart.busy_cycles", busy_n, 36);
        check("restart.done_cycle", done_cyc, 37);

        // LOG2N=3, back-to-back start the cycle after done
        busy_n = 0; rd_n = 0; done_cyc = -1; done2_cyc = -1;
        b3.start = 1'b1;
        tick();
        for (int k = 1; k <= 36; k++) begin
            if (b3.busy) busy_n++;
            if (b3.rd_en) rd_n++;
            if (b3.done) begin
                if (done_cyc < 0) done_cyc = k;
                else done2_cyc = k;
            end
            b3.start = (k == 17);
            tick();
        end
        check("n8.done_cycle", done_cyc, 16);
        check("n8.done2_cycle", done2_cyc, 33);
        check("n8.busy_cycles", busy_n, 30);
        check("n8.rd_cycles", rd_n, 24);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
